// File: rtl/multiplicador_pkg.sv
// Shared definitions for the multiplicador block: FSM state encoding,
// operand/product widths and the step count of the shift-and-add build
// (selected with the MULT_SHIFTADD_EN macro in multiplicador.sv).
package multiplicador_pkg;

    localparam int OPERAND_W      = 4;
    localparam int PRODUCT_W      = 8;
    localparam int SHIFTADD_STEPS = 4;
    localparam int CNT_W          = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Zero-extend an operand to the product width.
    function automatic logic [PRODUCT_W-1:0] widen(input logic [OPERAND_W-1:0] x);
        return {{(PRODUCT_W-OPERAND_W){1'b0}}, x};
    endfunction

endpackage

// File: rtl/multiplicador_if.sv
// Request/result bundle of the multiplicador.
//
// Handshake: init is a start request that the block takes only while its FSM
// is in IDLE (the "ready" condition); on the accepting edge SW is captured and
// done is cleared. done is a level, not a pulse: it rises when resultado holds
// the finished product and stays high until the next accepted init. init seen
// outside IDLE is ignored. state is a read-only debug view of the FSM.
interface multiplicador_if;
    import multiplicador_pkg::*;

    logic                     init;
    logic [2*OPERAND_W-1:0]   SW;
    logic [PRODUCT_W-1:0]     resultado;
    logic                     done;
    state_t                   state;

    modport master (output init, output SW,
                    input  resultado, input done, input state);

    modport slave  (input  init, input SW,
                    output resultado, output done, output state);

endinterface

// File: rtl/multiplicador.sv
// 4x4 unsigned sequential multiplier.
// Default build: repeated addition of A, B times (latency 2*B+2).
// With MULT_SHIFTADD_EN defined: four shift-and-add steps (fixed latency 10).
// Interface, reset and handshake behaviour are the same in both builds.
module multiplicador
    import multiplicador_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    multiplicador_if.slave  bus
);

    state_t                 state_q, state_n;
    logic [OPERAND_W-1:0]   a_q, a_n;
    logic [OPERAND_W-1:0]   b_q, b_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic [PRODUCT_W-1:0]   res_q, res_n;
    logic                   done_q, done_n;

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        cnt_n   = cnt_q;
        res_n   = res_q;
        done_n  = done_q;
        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    a_n     = bus.SW[2*OPERAND_W-1:OPERAND_W];
                    b_n     = bus.SW[OPERAND_W-1:0];
                    cnt_n   = '0;
                    res_n   = '0;
                    done_n  = 1'b0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
`ifdef MULT_SHIFTADD_EN
                if (cnt_q == CNT_W'(SHIFTADD_STEPS)) state_n = DONE;
                else                                 state_n = ADD;
`else
                if (b_q == '0) state_n = DONE;
                else           state_n = ADD;
`endif
            end
            ADD: begin
`ifdef MULT_SHIFTADD_EN
                // b is shifted right each step, so b[0] is multiplier bit cnt.
                if (b_q[0]) res_n = res_q + (widen(a_q) << cnt_q);
                b_n   = b_q >> 1;
                cnt_n = cnt_q + CNT_W'(1);
`else
                res_n = res_q + widen(a_q);
                b_n   = b_q - OPERAND_W'(1);
`endif
                state_n = CHECK;
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            cnt_q   <= cnt_n;
            res_q   <= res_n;
            done_q  <= done_n;
        end
    end

    assign bus.resultado = res_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;

endmodule
